// File: rtl/disp_conf_packer.sv
`default_nettype none
// ============================================================================
// Module   : disp_conf_packer
// Brief    : Thresholds decimated {disparity, confidence} pixels against a
//            per-frame latched confidence threshold. Packs the resulting
//            pixel bytes four to a 32-bit word, little-endian, with
//            start/end-of-frame flags. Reports per-frame pass counts.
// Revision : 1.0 - initial release
// ============================================================================
module disp_conf_packer #(
  parameter int disp_bits    = 5,
  parameter int frame_width  = 320,
  parameter int frame_height = 240
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [disp_bits+7:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             conf_thresh,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [16:0]            pass_count,
  output logic                   frame_done
);

  localparam int COL_W = (frame_width  > 1) ? $clog2(frame_width)  : 1;
  localparam int ROW_W = (frame_height > 1) ? $clog2(frame_height) : 1;
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(frame_width - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(frame_height - 1);

  // Registered state
  logic             rdy_q,        rdy_d;
  logic [1:0]       idx_q,        idx_d;
  logic [23:0]      hold_q,       hold_d;
  logic             hold_sop_q,   hold_sop_d;
  logic [7:0]       thresh_q,     thresh_d;
  logic [COL_W-1:0] col_q,        col_d;
  logic [ROW_W-1:0] row_q,        row_d;
  logic [16:0]      acc_q,        acc_d;
  logic [31:0]      out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic             out_sop_q,    out_sop_d;
  logic             out_eop_q,    out_eop_d;
  logic [16:0]      pass_count_q, pass_count_d;
  logic             frame_done_q, frame_done_d;

  // Combinational helpers
  logic                 w_stall;
  logic                 w_in_xfer;
  logic                 w_first_pix;
  logic                 w_last_col;
  logic                 w_last_pix;
  logic [7:0]           w_thr_eff;
  logic [7:0]           w_conf;
  logic [disp_bits-1:0] w_disp;
  logic                 w_pass;
  logic [7:0]           w_byte;
  logic [17:0]          w_acc_sum;
  logic [16:0]          w_acc_sat;

  // Only a completed word that cannot leave (output full and not draining)
  // blocks the input; the first three bytes of a group always fit.
  assign w_stall   = (idx_q == 2'd3) && out_valid_q && !out_ready;
  assign in_ready  = rdy_q && !w_stall;
  assign w_in_xfer = in_valid && in_ready;

  assign w_first_pix = (col_q == '0) && (row_q == '0);
  assign w_last_col  = (col_q == C_COL_LAST);
  assign w_last_pix  = w_last_col && (row_q == C_ROW_LAST);

  // The first pixel of a frame is judged against the live threshold, which
  // is latched at that same moment for the rest of the frame.
  assign w_thr_eff = w_first_pix ? conf_thresh : thresh_q;
  assign w_conf    = in_data[7:0];
  assign w_disp    = in_data[disp_bits+7:8];
  assign w_pass    = (w_conf >= w_thr_eff);
  assign w_byte    = w_pass ? {1'b1, 7'(w_disp)} : 8'h00;

  assign w_acc_sum = {1'b0, acc_q} + {17'd0, w_pass};
  assign w_acc_sat = w_acc_sum[17] ? 17'h1FFFF : w_acc_sum[16:0];

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign pass_count = pass_count_q;
  assign frame_done = frame_done_q;

  // Next-state logic: byte packing, output handshake, frame position, counts
  always_comb begin
    rdy_d        = 1'b1;
    idx_d        = idx_q;
    hold_d       = hold_q;
    hold_sop_d   = hold_sop_q;
    thresh_d     = thresh_q;
    col_d        = col_q;
    row_d        = row_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    pass_count_d = pass_count_q;
    frame_done_d = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_in_xfer) begin
      idx_d = idx_q + 2'd1;

      case (idx_q)
        2'd0: begin
          hold_d[7:0] = w_byte;
          hold_sop_d  = w_first_pix;
        end
        2'd1: hold_d[15:8]  = w_byte;
        2'd2: hold_d[23:16] = w_byte;
        default: begin
          // A departing word (if any) is replaced in the same cycle.
          out_data_d  = {w_byte, hold_q};
          out_valid_d = 1'b1;
          out_sop_d   = hold_sop_q;
          out_eop_d   = w_last_pix;
        end
      endcase

      if (w_first_pix) begin
        thresh_d = conf_thresh;
      end

      if (w_last_col) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (w_last_pix) begin
        pass_count_d = w_acc_sat;
        frame_done_d = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d = w_acc_sat;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q        <= 1'b0;
      idx_q        <= '0;
      hold_q       <= '0;
      hold_sop_q   <= 1'b0;
      thresh_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      pass_count_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rdy_q        <= rdy_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      hold_sop_q   <= hold_sop_d;
      thresh_q     <= thresh_d;
      col_q        <= col_d;
      row_q        <= row_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      pass_count_q <= pass_count_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/disp_conf_packer.md
DISP_CONF_PACKER -- requirements
Module: disp_conf_packer

Interface
REQ-001 The block SHALL have parameter disp_bits, default 5, the disparity field width (1..7).
REQ-002 The block SHALL have parameter frame_width, default 320, pixels per line (multiple of 4).
REQ-003 The block SHALL have parameter frame_height, default 240, lines per frame.
REQ-004 Port clk  input  1  is the single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port in_data  input  disp_bits+8  {disp[disp_bits-1:0], conf[7:0]}, one decimated pixel.
REQ-007 Port in_valid  input  1  in_data is valid.
REQ-008 Port in_ready  output  1  the block accepts in_data this cycle.
REQ-009 Port conf_thresh  input  8  minimum confidence for a pixel to pass.
REQ-010 Port out_data  output  32  four packed pixel bytes.
REQ-011 Port out_valid  output  1  out_data, out_sop and out_eop are valid.
REQ-012 Port out_ready  input  1  the downstream sink accepts the word.
REQ-013 Port out_sop  output  1  the word is the first of a frame.
REQ-014 Port out_eop  output  1  the word is the last of a frame.
REQ-015 Port pass_count  output  17  pixels passing threshold in the last completed frame.
REQ-016 Port frame_done  output  1  one-cycle pulse when pass_count updates.

Function
REQ-017 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer on a cycle with out_valid && out_ready.
REQ-018 The pixel byte SHALL be {1'b1, zeros, disp} (disp right-aligned) when conf >= thresh_lat; otherwise it SHALL be 8'h00.
REQ-019 thresh_lat SHALL load conf_thresh on the transfer of the first pixel of each frame and on that same pixel's evaluation; it SHALL hold for the rest of the frame.
REQ-020 Bytes SHALL be packed little-endian: the first pixel of a group goes to out_data[7:0], the fourth to out_data[31:24].
REQ-021 A 2-bit byte index SHALL advance on each input transfer and wrap 3->0; bytes 0-2 go to a holding register.
REQ-022 On a byte-3 transfer, the completed word SHALL load the output register, and out_valid SHALL rise on the next cycle (latency 1 cycle from the 4th input).
REQ-023 in_ready SHALL be low only when byte index == 3 and out_valid && !out_ready; in all other cases it SHALL be high.
REQ-024 When out_valid is high and out_ready is high on a byte-3 transfer, the new word SHALL replace the old one and out_valid SHALL stay high, with no bubble and no loss.
REQ-025 out_valid SHALL stay high, with out_data, out_sop and out_eop stable, until an output transfer occurs.
REQ-026 A column counter (0..frame_width-1) and a row counter (0..frame_height-1) SHALL advance per input transfer, wrapping the column to 0 and incrementing the row, and both SHALL return to 0 after the last pixel of a frame.
REQ-027 out_sop SHALL be 1 for the word containing pixel (row 0, col 0); out_eop SHALL be 1 for the word containing the last pixel of the frame.
REQ-028 A pass accumulator SHALL count passing pixels.
REQ-029 On the final pixel of a frame, pass_count SHALL load the accumulator plus that pixel's pass bit, frame_done SHALL pulse the next cycle, and the accumulator SHALL clear.
REQ-030 pass_count SHALL saturate at 2^17-1.

Reset
REQ-031 On reset_n low, the block SHALL clear the counters, byte index, holding register, thresh_lat and accumulator, and SHALL drive out_valid, out_sop, out_eop, frame_done, out_data and pass_count to 0, all immediately and without a clock.
REQ-032 in_ready SHALL be 0 while reset_n is low and SHALL be 1 on the first clock after release.
REQ-033 A reset asserted mid-frame SHALL discard partial words and in-flight frame state; the next accepted pixel is row 0, col 0.

Verification
REQ-034 Test 1: thresh=100, four pixels {disp=3, conf=200}, {5, 50}, {31, 100}, {0, 255}, out_ready=1 -> one word 32'h80_9F_00_83 (out_data[31:0] = 80 9F 00 83), 1 cycle after the 4th input, with out_sop=1.
REQ-035 Test 2: out_ready=0 and a continuous input stream -> 3 more pixels are accepted, then in_ready=0 at byte index 3 while out_data is held; after out_ready=1 the stream resumes with no loss or duplication.
REQ-036 Test 3: a full 320x240 frame with every conf=255 -> 19200 words, out_eop only on word 19199, pass_count=76800 and a single frame_done pulse.
REQ-037 Test 4: conf_thresh changed mid-frame from 10 to 250 -> the current frame still uses 10; the next frame uses 250.
REQ-038 Test 5: reset_n pulsed low after 6 pixels -> outputs go 0 asynchronously; the next 4 pixels form a word with out_sop=1.
REQ-039 Test 6: random in_valid and out_ready over 3 frames -> a scoreboard matches every byte, sop/eop position and pass_count.
